// File: rtl/aes_control_nlane_if.sv
// Host/datapath-facing bundle of the N-lane AES control block.
//   slave  : the control block (consumes in_en/key_len, drives everything else)
//   master : the host side / bench (drives in_en/key_len, observes the rest)
// Signals:
//   in_en, key_len            host block strobe and key-size select
//   start, lane_idx           combinational acceptance and its lane
//   key_ready, last_round     round-key request, MixColumns bypass
//   out_en, out_lane, done    per-lane output strobe, batch completion
//   busy                      batch in process (in_en rejected)
//   in_en_collision_irq_pulse rejected-in_en run detected
//   mode_err_pulse            illegal key_len seen in IDLE
interface aes_control_nlane_if #(
  parameter int LANES = 3
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic          in_en;
  logic [1:0]    key_len;
  logic          start;
  logic [LW-1:0] lane_idx;
  logic          key_ready;
  logic          last_round;
  logic          out_en;
  logic [LW-1:0] out_lane;
  logic          busy;
  logic          done;
  logic          in_en_collision_irq_pulse;
  logic          mode_err_pulse;

  modport slave (
    input  in_en, key_len,
    output start, lane_idx, key_ready, last_round, out_en, out_lane,
           busy, done, in_en_collision_irq_pulse, mode_err_pulse
  );

  modport master (
    output in_en, key_len,
    input  start, lane_idx, key_ready, last_round, out_en, out_lane,
           busy, done, in_en_collision_irq_pulse, mode_err_pulse
  );
endinterface

// File: rtl/aes_control_nlane.sv
// Control FSM for an interleaved AES round datapath.
// Accepts up to LANES blocks per batch (one per cycle, lane 0 mandatory),
// then sequences NR+1 round-key requests CYC_PER_ROUND cycles apart, flags
// the final round, and drains one output slot per lane.
// Ports:
//   clk  : clock
//   kill : synchronous active-high reset / batch abort
//   bus  : aes_control_nlane_if.slave (see interface header)
module aes_control_nlane #(
  parameter int CYC_PER_ROUND = 4,
  parameter int LANES         = 3,
  parameter int CNT_W         = 7
) (
  input  logic                 clk,
  input  logic                 kill,
  aes_control_nlane_if.slave   bus
);

  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PH_W = $clog2(CYC_PER_ROUND);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  function automatic int nr_of(input logic [1:0] kl);
    case (kl)
      2'b01:   return 12;
      2'b10:   return 14;
      default: return 10;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // n within the batch (0 in IDLE)
  logic [PH_W-1:0]  ph_q, ph_d;       // cycle within round, or drain lane index
  logic [1:0]       kl_q, kl_d;       // latched key_len of the batch
  logic [LANES-1:0] mask_q, mask_d;   // lanes that received a block
  logic             rej_q;            // in_en was rejected last cycle

  logic             start, rejected;
  logic [LW-1:0]    lane_idx;
  logic [CNT_W-1:0] run_end, last_start;

  logic             key_ready_q, last_round_q, out_en_q, busy_q, done_q;
  logic             coll_q, mode_err_q;
  logic [LW-1:0]    out_lane_q;
  logic             key_ready_d, last_round_d, out_en_d, busy_d, done_d;
  logic             coll_d, mode_err_d;
  logic [LW-1:0]    out_lane_d;

  // Last cycle of the final round, and first cycle of the final round.
  assign run_end    = CNT_W'((nr_of(kl_q) + 1) * CYC_PER_ROUND);
  assign last_start = CNT_W'(nr_of(kl_q) * CYC_PER_ROUND + 1);

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    kl_d     = kl_q;
    mask_d   = mask_q;
    start    = 1'b0;
    lane_idx = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_en && bus.key_len != 2'b11) begin
          start   = 1'b1;
          kl_d    = bus.key_len;
          mask_d  = LANES'(1);
          cnt_d   = CNT_W'(1);
          ph_d    = '0;
          state_d = (LANES == 1) ? RUN : LOAD;
        end
      end
      LOAD: begin
        start    = bus.in_en;
        lane_idx = LW'(cnt_q);
        if (bus.in_en) mask_d = mask_q | (LANES'(1) << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
        ph_d  = ph_q + PH_W'(1);
        if (cnt_q == CNT_W'(LANES - 1)) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        ph_d  = (ph_q == PH_W'(CYC_PER_ROUND - 1)) ? '0 : ph_q + PH_W'(1);
        if (cnt_q == run_end) begin
          state_d = DRAIN;
          ph_d    = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        ph_d  = ph_q + PH_W'(1);
        if (ph_q == PH_W'(LANES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ph_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (kill) start = 1'b0;

    // Registered outputs are precomputed from the next state so they line
    // up with the cycle that state describes.
    key_ready_d  = (state_d == LOAD || state_d == RUN) && (ph_d == '0);
    last_round_d = (state_d == RUN) && (cnt_d >= last_start);
    busy_d       = (state_d == RUN) || (state_d == DRAIN);
    out_en_d     = (state_d == DRAIN) && |(mask_d & (LANES'(1) << ph_d));
    out_lane_d   = (state_d == DRAIN) ? LW'(ph_d) : '0;
    done_d       = (state_d == DRAIN) && (ph_d == PH_W'(LANES - 1));

    // One collision pulse per contiguous run of rejected in_en.
    rejected   = bus.in_en && busy_q;
    coll_d     = rejected && !rej_q;
    mode_err_d = (state_q == IDLE) && bus.in_en && (bus.key_len == 2'b11);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so each sees pre-edge values.
    if (kill) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ph_q         <= '0;
      kl_q         <= 2'b00;
      mask_q       <= '0;
      rej_q        <= 1'b0;
      key_ready_q  <= 1'b0;
      last_round_q <= 1'b0;
      out_en_q     <= 1'b0;
      out_lane_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coll_q       <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      kl_q         <= kl_d;
      mask_q       <= mask_d;
      rej_q        <= rejected;
      key_ready_q  <= key_ready_d;
      last_round_q <= last_round_d;
      out_en_q     <= out_en_d;
      out_lane_q   <= out_lane_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      coll_q       <= coll_d;
      mode_err_q   <= mode_err_d;
    end
  end

  assign bus.start                     = start;
  assign bus.lane_idx                  = lane_idx;
  assign bus.key_ready                 = key_ready_q;
  assign bus.last_round                = last_round_q;
  assign bus.out_en                    = out_en_q;
  assign bus.out_lane                  = out_lane_q;
  assign bus.busy                      = busy_q;
  assign bus.done                      = done_q;
  assign bus.in_en_collision_irq_pulse = coll_q;
  assign bus.mode_err_pulse            = mode_err_q;

endmodule

// File: doc/aes_control_nlane.md
Name: aes_control_nlane

Overview:
- Parametrised successor to the fixed 3-lane, 4-cycle-round, AES-128-only control FSM.
- Sequences LANES interleaved blocks through a round datapath that takes CYC_PER_ROUND cycles per round.
- Round count (10/12/14) is selected per batch from key_len.
- Generates round-key requests, last-round (no MixColumns) flag, per-lane output strobes, busy status and collision/mode-error reporting. Sits between the host input interface and the round/key-expansion datapath.

Parameters:
- CYC_PER_ROUND, 4: datapath cycles per round; legal range 2..8.
- LANES, 3: interleaved blocks per batch; 1 <= LANES <= CYC_PER_ROUND.
- CNT_W, 7: cycle counter width; must satisfy 2^CNT_W > 15*CYC_PER_ROUND+LANES+1.

Ports:
- clk  in  1  clock.
- kill  in  1  reset, synchronous, active-high; also aborts any batch in flight.
- in_en  in  1  block-valid strobe from host.
- key_len  in  2  00=128 (NR=10), 01=192 (NR=12), 10=256 (NR=14), 11=illegal; sampled with first lane.
- start  out  1  combinational; in_en accepted this cycle.
- lane_idx  out  clog2(LANES) (min 1)  combinational; lane index of accepted block (valid with start).
- key_ready  out  1  one-cycle round-key request.
- last_round  out  1  high during final round cycles (MixColumns bypass).
- out_en  out  1  output strobe, one per valid lane.
- out_lane  out  clog2(LANES) (min 1)  lane index qualifying out_en.
- busy  out  1  batch in process; in_en rejected.
- done  out  1  pulse with final out_en cycle of batch (or with last slot if no lane valid... never: lane 0 always valid).
- in_en_collision_irq_pulse  out  1  collision pulse.
- mode_err_pulse  out  1  illegal key_len pulse.

Behaviour:
- Reset (kill=1 at an edge): all registered outputs 0, FSM=IDLE, counter 0, lane mask 0, NR latch 10; in_en in a kill cycle is ignored; abort mid-batch drops all pending out_en.
- FSM: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
- Timing ref: n=0 is the cycle in IDLE where in_en=1 and key_len!=11 (start=1, lane_idx=0); NR latched, lane mask bit0 set, FSM->LOAD.
- IDLE with in_en=1 and key_len=11: start=0, no state change, mode_err_pulse=1 at n+1.
- LOAD, cycles n=1..LANES-1: start=in_en, lane_idx=n; accepted lane sets mask bit n; key_len ignored; a slot without in_en leaves its lane empty. LOAD->RUN after slot LANES-1 (LANES=1: IDLE->RUN directly).
- busy: 1 for n = LANES .. (NR+1)*CYC_PER_ROUND+LANES; 0 otherwise.
- key_ready: 1 at n = 1 + r*CYC_PER_ROUND, r = 0..NR (NR+1 keys, incl. initial AddRoundKey).
- last_round: 1 for n = 1+NR*CYC .. (NR+1)*CYC.
- DRAIN: n = 1+(NR+1)*CYC + i, i=0..LANES-1; out_en = mask[i], out_lane=i. done=1 at i=LANES-1 regardless of mask.
- Next cycle FSM->IDLE, busy=0; in_en accepted that same cycle (back-to-back batches, no bubble).
- Collision: in_en=1 while busy=1 -> start=0, ignored; in_en_collision_irq_pulse=1 on the cycle after the first cycle of each contiguous rejected in_en run (one pulse per run, not per cycle).
- in_en during LOAD is never a collision. in_en in the DRAIN->IDLE cycle is accepted normally.
- All outputs except start/lane_idx registered; counter saturation impossible by CNT_W rule.

Test Plan:
- Default params, key_len=00, in_en at n=0,1,2 -> start n=0..2; busy n=3..47; key_ready n=1,5,..,41 (11 pulses); last_round n=41..44; out_en n=45,46,47 with out_lane 0,1,2; done n=47; busy=0 n=48.
- key_len=10, in_en only n=0 -> 15 key_ready pulses (last n=57); last_round n=57..60; out_en only n=61 (lane 0); n=62,63 out_en=0; done n=63.
- key_len=11 in IDLE -> start=0, mode_err_pulse next cycle, busy stays 0; then key_len=01 accepted -> last key_ready n=49.
- in_en held high n=3..6 during batch -> single in_en_collision_irq_pulse at n=4, no state disturbance; second run n=10 -> pulse at n=11.
- kill at n=20 -> next cycle all outputs 0, IDLE; in_en at n=22 starts fresh batch (key_ready at n'=1).
- LANES=1, CYC_PER_ROUND=2, key_len=00: busy n=1..23, out_en n=23, done n=23; back-to-back in_en at n=24 accepted.
